// File: rtl/ct_had_ddu_ctrl_if.sv
// Bundle between the HAD upload engine, the JTAG IR/state decode and the HAD regs block.
// master = upload engine side, slave = the JTAG decode / regs block side.
interface ct_had_ddu_ctrl_if #(
    parameter int DATAW = 64
);
    logic             had_ddu_en;
    logic             x_sm_xx_update_dr_en;
    logic             x_sm_xx_capture_dr_en;
    logic             ir_xx_uaddr_reg_sel;
    logic             ir_xx_udata_reg_sel;
    logic [63:0]      ir_xx_wdata;
    logic             regs_ddu_inst_ack;
    logic             regs_ddu_inst_done;
    logic             regs_ddu_inst_excp;
    logic [DATAW-1:0] regs_ddu_wbbr;

    logic             ddu_regs_inst_vld;
    logic [31:0]      ddu_regs_ir;
    logic             ddu_regs_ffy;
    logic [63:0]      ddu_regs_wbbr;
    logic [63:0]      ddu_regs_uaddr;
    logic [DATAW-1:0] ddu_regs_udata;
    logic [2:0]       ddu_regs_status;

    modport master (
        input  had_ddu_en, x_sm_xx_update_dr_en, x_sm_xx_capture_dr_en,
               ir_xx_uaddr_reg_sel, ir_xx_udata_reg_sel, ir_xx_wdata,
               regs_ddu_inst_ack, regs_ddu_inst_done, regs_ddu_inst_excp, regs_ddu_wbbr,
        output ddu_regs_inst_vld, ddu_regs_ir, ddu_regs_ffy, ddu_regs_wbbr,
               ddu_regs_uaddr, ddu_regs_udata, ddu_regs_status
    );

    modport slave (
        output had_ddu_en, x_sm_xx_update_dr_en, x_sm_xx_capture_dr_en,
               ir_xx_uaddr_reg_sel, ir_xx_udata_reg_sel, ir_xx_wdata,
               regs_ddu_inst_ack, regs_ddu_inst_done, regs_ddu_inst_excp, regs_ddu_wbbr,
        input  ddu_regs_inst_vld, ddu_regs_ir, ddu_regs_ffy, ddu_regs_wbbr,
               ddu_regs_uaddr, ddu_regs_udata, ddu_regs_status
    );
endinterface

// File: rtl/ct_had_ddu_ctrl.sv
// HAD debug data upload engine: per beat, injects an address load into x1 and
// `ld x2,0(x1)`, captures the load result for JTAG scan-out, then steps the address by 8.
module ct_had_ddu_ctrl #(
    parameter int ADDRW = 40,
    parameter int DATAW = 64
) (
    input  logic                 cpuclk,
    input  logic                 cpurst,
    ct_had_ddu_ctrl_if.master    bus
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ADDR_REQ  = 3'd1;
    localparam logic [2:0] ADDR_WAIT = 3'd2;
    localparam logic [2:0] LD_REQ    = 3'd3;
    localparam logic [2:0] LD_WAIT   = 3'd4;
    localparam logic [2:0] FULL      = 3'd5;

    localparam logic [31:0] IR_ADDR = 32'h0000_8093;
    localparam logic [31:0] IR_LD   = 32'h0000_B103;

    logic [2:0]       state_q, state_d;
    logic [63:0]      uaddr_q, uaddr_d;
    logic [DATAW-1:0] udata_q, udata_d;
    logic             err_q,   err_d;
    logic             dvld_q,  dvld_d;

    logic             start_s;
    logic             capture_s;
    logic             busy_s;
    logic             vld_s;
    logic [31:0]      ir_s;
    logic             ffy_s;
    logic [63:0]      wbbr_s;

    assign start_s   = bus.x_sm_xx_update_dr_en & bus.ir_xx_uaddr_reg_sel & bus.had_ddu_en;
    assign capture_s = bus.x_sm_xx_capture_dr_en & bus.ir_xx_udata_reg_sel;

    // Next-state and datapath update; a disable never abandons an instruction already acked.
    always_comb begin
        state_d = state_q;
        uaddr_d = uaddr_q;
        udata_d = udata_q;
        err_d   = err_q;
        dvld_d  = dvld_q;
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    uaddr_d = bus.ir_xx_wdata;
                    err_d   = 1'b0;
                    dvld_d  = 1'b0;
                    state_d = ADDR_REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR_REQ: begin
                if (bus.regs_ddu_inst_ack) begin
                    state_d = ADDR_WAIT;
                end else if (!bus.had_ddu_en) begin
                    state_d = IDLE;
                end else begin
                    state_d = ADDR_REQ;
                end
            end
            ADDR_WAIT: begin
                if (!bus.regs_ddu_inst_done) begin
                    state_d = ADDR_WAIT;
                end else if (!bus.had_ddu_en) begin
                    state_d = IDLE;
                end else if (bus.regs_ddu_inst_excp) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = LD_REQ;
                end
            end
            LD_REQ: begin
                if (bus.regs_ddu_inst_ack) begin
                    state_d = LD_WAIT;
                end else if (!bus.had_ddu_en) begin
                    state_d = IDLE;
                end else begin
                    state_d = LD_REQ;
                end
            end
            LD_WAIT: begin
                if (!bus.regs_ddu_inst_done) begin
                    state_d = LD_WAIT;
                end else if (!bus.had_ddu_en) begin
                    state_d = IDLE;
                end else if (bus.regs_ddu_inst_excp) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    udata_d = bus.regs_ddu_wbbr;
                    dvld_d  = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (!bus.had_ddu_en) begin
                    state_d = IDLE;
                end else if (capture_s) begin
                    dvld_d  = 1'b0;
                    uaddr_d = uaddr_q + 64'd8;
                    state_d = ADDR_REQ;
                end else begin
                    state_d = FULL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge cpuclk) begin
        if (cpurst) begin
            state_q <= IDLE;
            uaddr_q <= 64'd0;
            udata_q <= {DATAW{1'b0}};
            err_q   <= 1'b0;
            dvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            uaddr_q <= uaddr_d;
            udata_q <= udata_d;
            err_q   <= err_d;
            dvld_q  <= dvld_d;
        end
    end

    // Injection request decoded from state; the LD encoding is the idle default.
    always_comb begin
        vld_s  = 1'b0;
        ir_s   = IR_LD;
        ffy_s  = 1'b0;
        wbbr_s = 64'd0;
        case (state_q)
            ADDR_REQ: begin
                vld_s  = 1'b1;
                ir_s   = IR_ADDR;
                ffy_s  = 1'b1;
                wbbr_s = {{(64-ADDRW){1'b0}}, uaddr_q[ADDRW-1:0]};
            end
            LD_REQ: begin
                vld_s  = 1'b1;
            end
            default: begin
                vld_s  = 1'b0;
            end
        endcase
    end

    assign busy_s = (state_q != IDLE) && (state_q != FULL);

    assign bus.ddu_regs_inst_vld = vld_s;
    assign bus.ddu_regs_ir       = ir_s;
    assign bus.ddu_regs_ffy      = ffy_s;
    assign bus.ddu_regs_wbbr     = wbbr_s;
    assign bus.ddu_regs_uaddr    = uaddr_q;
    assign bus.ddu_regs_udata    = udata_q;
    assign bus.ddu_regs_status   = {err_q, busy_s, dvld_q};

endmodule

// File: tb/tb_ct_had_ddu_ctrl.sv
// Scoreboard bench for ct_had_ddu_ctrl: expected injections and status transitions are
// queued by the stimulus and popped by a negedge monitor when the DUT presents them.
module tb_ct_had_ddu_ctrl;

    typedef struct packed {
        logic [31:0] ir;
        logic        ffy;
        logic [63:0] wbbr;
    } inj_t;

    typedef struct packed {
        logic [2:0]  status;
        logic [63:0] uaddr;
        logic [63:0] udata;
    } st_t;

    logic clk;
    logic rst;
    ct_had_ddu_ctrl_if bus_if ();

    ct_had_ddu_ctrl u_dut (
        .cpuclk (clk),
        .cpurst (rst),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks;
    int   passes;
    inj_t inj_q[$];
    st_t  st_q[$];
    logic mon_en;
    logic [2:0] prev_status;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: compare each accepted injection and each status transition against the queues.
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_status = bus_if.ddu_regs_status;
        end else begin
            if (bus_if.ddu_regs_inst_vld && bus_if.regs_ddu_inst_ack) begin
                checks++;
                if (inj_q.size() == 0) begin
                    $display("FAIL inj_unexpected: got ir=%h ffy=%b wbbr=%h expected none",
                             bus_if.ddu_regs_ir, bus_if.ddu_regs_ffy, bus_if.ddu_regs_wbbr);
                end else begin
                    inj_t e;
                    e = inj_q.pop_front();
                    if (bus_if.ddu_regs_ir === e.ir && bus_if.ddu_regs_ffy === e.ffy &&
                        bus_if.ddu_regs_wbbr === e.wbbr) passes++;
                    else $display("FAIL inj: got ir=%h ffy=%b wbbr=%h expected ir=%h ffy=%b wbbr=%h",
                                  bus_if.ddu_regs_ir, bus_if.ddu_regs_ffy, bus_if.ddu_regs_wbbr,
                                  e.ir, e.ffy, e.wbbr);
                end
            end
            if (bus_if.ddu_regs_status !== prev_status) begin
                checks++;
                if (st_q.size() == 0) begin
                    $display("FAIL status_unexpected: got status=%b (from %b) expected no change",
                             bus_if.ddu_regs_status, prev_status);
                end else begin
                    st_t s;
                    s = st_q.pop_front();
                    if (bus_if.ddu_regs_status === s.status && bus_if.ddu_regs_uaddr === s.uaddr &&
                        bus_if.ddu_regs_udata === s.udata) passes++;
                    else $display("FAIL status: got st=%b uaddr=%h udata=%h expected st=%b uaddr=%h udata=%h",
                                  bus_if.ddu_regs_status, bus_if.ddu_regs_uaddr, bus_if.ddu_regs_udata,
                                  s.status, s.uaddr, s.udata);
                end
            end
            prev_status = bus_if.ddu_regs_status;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_st(input logic [2:0] st, input logic [63:0] a, input logic [63:0] d);
        st_t s;
        s.status = st; s.uaddr = a; s.udata = d;
        st_q.push_back(s);
    endtask

    task automatic write_uaddr(input logic [63:0] a);
        bus_if.x_sm_xx_update_dr_en = 1'b1;
        bus_if.ir_xx_uaddr_reg_sel  = 1'b1;
        bus_if.ir_xx_wdata          = a;
        cyc();
        bus_if.x_sm_xx_update_dr_en = 1'b0;
        bus_if.ir_xx_uaddr_reg_sel  = 1'b0;
        bus_if.ir_xx_wdata          = 64'd0;
    endtask

    task automatic capture();
        bus_if.x_sm_xx_capture_dr_en = 1'b1;
        bus_if.ir_xx_udata_reg_sel   = 1'b1;
        cyc();
        bus_if.x_sm_xx_capture_dr_en = 1'b0;
        bus_if.ir_xx_udata_reg_sel   = 1'b0;
    endtask

    // Wait (bounded) for a request, then ack it one cycle later.
    task automatic serve_req(input logic [31:0] ir, input logic ffy, input logic [63:0] wbbr);
        inj_t e;
        for (int i = 0; i < 20; i++) begin
            if (bus_if.ddu_regs_inst_vld) break;
            cyc();
        end
        if (!bus_if.ddu_regs_inst_vld) begin
            checks++;
            $display("FAIL vld_timeout: got vld=0 expected vld=1 within 20 cycles");
        end else begin
            e.ir = ir; e.ffy = ffy; e.wbbr = wbbr;
            inj_q.push_back(e);
            cyc();
            bus_if.regs_ddu_inst_ack = 1'b1;
            cyc();
            bus_if.regs_ddu_inst_ack = 1'b0;
        end
    endtask

    task automatic serve_done(input logic excp, input logic [63:0] data);
        cyc();
        bus_if.regs_ddu_inst_done = 1'b1;
        bus_if.regs_ddu_inst_excp = excp;
        bus_if.regs_ddu_wbbr      = data;
        cyc();
        bus_if.regs_ddu_inst_done = 1'b0;
        bus_if.regs_ddu_inst_excp = 1'b0;
        bus_if.regs_ddu_wbbr      = 64'd0;
    endtask

    // Full beat: address injection, load injection, load result lands in FULL.
    task automatic beat(input logic [63:0] a, input logic [63:0] data);
        serve_req(32'h0000_8093, 1'b1, {24'd0, a[39:0]});
        serve_done(1'b0, 64'd0);
        serve_req(32'h0000_B103, 1'b0, 64'd0);
        push_st(3'b001, a, data);
        serve_done(1'b0, data);
    endtask

    initial begin
        logic [63:0] d [0:7];
        checks = 0; passes = 0; mon_en = 1'b0;
        d[0] = 64'h1122_3344_5566_7788; d[1] = 64'h0123_4567_89AB_CDEF;
        d[2] = 64'hDEAD_BEEF_CAFE_F00D; d[3] = 64'hA5A5_A5A5_5A5A_5A5A;
        d[4] = 64'h0F1E_2D3C_4B5A_6978; d[5] = 64'h5555_AAAA_5555_AAAA;
        d[6] = 64'h7777_8888_9999_0000; d[7] = 64'h9999_9999_9999_9999;
        rst = 1'b1;
        bus_if.had_ddu_en = 1'b0;
        bus_if.x_sm_xx_update_dr_en = 1'b0; bus_if.x_sm_xx_capture_dr_en = 1'b0;
        bus_if.ir_xx_uaddr_reg_sel = 1'b0;  bus_if.ir_xx_udata_reg_sel = 1'b0;
        bus_if.ir_xx_wdata = 64'd0;
        bus_if.regs_ddu_inst_ack = 1'b0; bus_if.regs_ddu_inst_done = 1'b0;
        bus_if.regs_ddu_inst_excp = 1'b0; bus_if.regs_ddu_wbbr = 64'd0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        chk("rst_vld",    {63'd0, bus_if.ddu_regs_inst_vld}, 64'd0);
        chk("rst_ir",     {32'd0, bus_if.ddu_regs_ir}, 64'h0000_B103);
        chk("rst_ffy",    {63'd0, bus_if.ddu_regs_ffy}, 64'd0);
        chk("rst_wbbr",   bus_if.ddu_regs_wbbr, 64'd0);
        chk("rst_uaddr",  bus_if.ddu_regs_uaddr, 64'd0);
        chk("rst_udata",  bus_if.ddu_regs_udata, 64'd0);
        chk("rst_status", {61'd0, bus_if.ddu_regs_status}, 64'd0);
        mon_en = 1'b1;

        // Single beat, then three more captures for a burst of four.
        bus_if.had_ddu_en = 1'b1;
        push_st(3'b010, 64'h8000_0000, 64'd0);
        write_uaddr(64'h8000_0000);
        beat(64'h8000_0000, d[0]);
        for (int i = 1; i < 4; i++) begin
            push_st(3'b010, 64'h8000_0000 + 64'(8 * i), d[i-1]);
            capture();
            beat(64'h8000_0000 + 64'(8 * i), d[i]);
        end

        // Load fault, then restart via a new address write.
        push_st(3'b010, 64'h8000_0020, d[3]);
        capture();
        serve_req(32'h0000_8093, 1'b1, 64'h8000_0020);
        serve_done(1'b0, 64'd0);
        serve_req(32'h0000_B103, 1'b0, 64'd0);
        push_st(3'b100, 64'h8000_0020, d[3]);
        serve_done(1'b1, 64'hBAD0_BAD0_BAD0_BAD0);
        push_st(3'b010, 64'h4000_0000, d[3]);
        write_uaddr(64'h4000_0000);
        beat(64'h4000_0000, d[4]);

        // Disable while the load is in flight: result discarded.
        push_st(3'b010, 64'h4000_0008, d[4]);
        capture();
        serve_req(32'h0000_8093, 1'b1, 64'h4000_0008);
        serve_done(1'b0, 64'd0);
        serve_req(32'h0000_B103, 1'b0, 64'd0);
        bus_if.had_ddu_en = 1'b0;
        push_st(3'b000, 64'h4000_0008, d[4]);
        serve_done(1'b0, d[7]);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 5; i++) begin
                seen = seen | bus_if.ddu_regs_inst_vld;
                cyc();
            end
            chk("no_vld_after_disable", {63'd0, seen}, 64'd0);
        end
        write_uaddr(64'h1234_0000);
        chk("start_ignored_when_disabled", bus_if.ddu_regs_uaddr, 64'h4000_0008);

        // Wrap: top-of-space address, then capture rolls to zero.
        bus_if.had_ddu_en = 1'b1;
        push_st(3'b010, 64'hFFFF_FFFF_FFFF_FFF8, d[4]);
        write_uaddr(64'hFFFF_FFFF_FFFF_FFF8);
        beat(64'hFFFF_FFFF_FFFF_FFF8, d[5]);
        push_st(3'b010, 64'd0, d[5]);
        capture();
        beat(64'd0, d[6]);

        // Ignored events while busy, then reset mid ADDR_REQ.
        push_st(3'b010, 64'd8, d[6]);
        capture();
        write_uaddr(64'h0000_0000_1234_5678);
        chk("uaddr_write_while_busy", bus_if.ddu_regs_uaddr, 64'd8);
        capture();
        chk("capture_not_full_uaddr", bus_if.ddu_regs_uaddr, 64'd8);
        chk("capture_not_full_status", {61'd0, bus_if.ddu_regs_status}, 64'h2);
        chk("still_addr_req_ir", {32'd0, bus_if.ddu_regs_ir}, 64'h0000_8093);
        push_st(3'b000, 64'd0, 64'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_vld",   {63'd0, bus_if.ddu_regs_inst_vld}, 64'd0);
        chk("mid_rst_ir",    {32'd0, bus_if.ddu_regs_ir}, 64'h0000_B103);
        chk("mid_rst_ffy",   {63'd0, bus_if.ddu_regs_ffy}, 64'd0);
        chk("mid_rst_wbbr",  bus_if.ddu_regs_wbbr, 64'd0);
        chk("mid_rst_udata", bus_if.ddu_regs_udata, 64'd0);

        repeat (3) cyc();
        chk("inj_queue_drained", 64'(inj_q.size()), 64'd0);
        chk("status_queue_drained", 64'(st_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
